// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, redirect flushes, memory freeze.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned LU_EX_BUBBLES = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_is_load,
  input  logic              m1_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] m1_rd,
  input  logic              ex_redirect,
  input  logic              dmem_busy,
  output logic              pc_en,
  output logic              fd_en,
  output logic              de_en,
  output logic              em_en,
  output logic              mm_en,
  output logic              mw_en,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              em_flush,
  output logic              mm_flush,
  output logic              mw_flush,
  output logic [1:0]        ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_freeze_cnt
`endif
);

  localparam int unsigned    CW       = $clog2(LU_EX_BUBBLES + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(LU_EX_BUBBLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FREEZE   = 2'd2
  } state_t;

  state_t        r_state, r_saved_state;
  logic [CW-1:0] r_cnt, r_saved_cnt;

  state_t        w_eff_state, w_nxt_state, w_nxt_saved_state;
  logic [CW-1:0] w_eff_cnt, w_nxt_cnt, w_nxt_saved_cnt;
  logic          w_lu_ex, w_lu_m1;
  logic          w_frz, w_redir, w_bubble;

  assign w_lu_ex = ex_is_load &&
                   ((id_rs1_used && (id_rs1 != '0) && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 != '0) && (id_rs2 == ex_rd)));
  assign w_lu_m1 = m1_is_load &&
                   ((id_rs1_used && (id_rs1 != '0) && (id_rs1 == m1_rd)) ||
                    (id_rs2_used && (id_rs2 != '0) && (id_rs2 == m1_rd)));

  // The first non-busy cycle in FREEZE already acts as the saved state, so no control cycle is lost.
  assign w_eff_state = (r_state == ST_FREEZE) ? r_saved_state : r_state;
  assign w_eff_cnt   = (r_state == ST_FREEZE) ? r_saved_cnt   : r_cnt;

  always_comb begin
    w_nxt_state       = w_eff_state;
    w_nxt_cnt         = w_eff_cnt;
    w_nxt_saved_state = r_saved_state;
    w_nxt_saved_cnt   = r_saved_cnt;
    w_frz             = 1'b0;
    w_redir           = 1'b0;
    w_bubble          = 1'b0;
    if (dmem_busy) begin
      w_frz             = 1'b1;
      w_nxt_state       = ST_FREEZE;
      w_nxt_saved_state = w_eff_state;
      w_nxt_saved_cnt   = w_eff_cnt;
    end else if (ex_redirect) begin
      w_redir     = 1'b1;
      w_nxt_state = ST_RUN;
      w_nxt_cnt   = '0;
    end else begin
      case (w_eff_state)
        ST_LU_STALL: begin
          w_bubble = 1'b1;
          if (w_eff_cnt <= CW'(1)) begin
            w_nxt_state = ST_RUN;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = w_eff_cnt - CW'(1);
          end
        end
        default: begin
          if (w_lu_ex) begin
            w_bubble = 1'b1;
            if (LU_EX_BUBBLES > 1) begin
              w_nxt_state = ST_LU_STALL;
              w_nxt_cnt   = CNT_LOAD;
            end
          end else if (w_lu_m1) begin
            w_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    de_en    = 1'b1;
    em_en    = 1'b1;
    mm_en    = 1'b1;
    mw_en    = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    em_flush = 1'b0;
    mm_flush = 1'b0;
    mw_flush = 1'b0;
    if (!n_rst) begin
      {pc_en, fd_en, de_en, em_en, mm_en, mw_en}  = '0;
      {fd_flush, de_flush, em_flush, mm_flush, mw_flush} = '1;
    end else if (w_frz) begin
      {pc_en, fd_en, de_en, em_en, mm_en, mw_en}  = '0;
    end else if (w_redir) begin
      fd_en    = 1'b0;
      de_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (w_bubble) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      de_flush = 1'b1;
    end
  end

  assign ctrl_state = r_state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_saved_state <= ST_RUN;
      r_saved_cnt   <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_saved_state <= w_nxt_saved_state;
      r_saved_cnt   <= w_nxt_saved_cnt;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] r_perf_bubble, r_perf_flush, r_perf_freeze;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_perf_bubble <= '0;
      r_perf_flush  <= '0;
      r_perf_freeze <= '0;
    end else begin
      if (w_bubble) r_perf_bubble <= r_perf_bubble + 32'd1;
      if (w_redir)  r_perf_flush  <= r_perf_flush + 32'd1;
      if (w_frz)    r_perf_freeze <= r_perf_freeze + 32'd1;
    end
  end

  assign perf_bubble_cnt = r_perf_bubble;
  assign perf_flush_cnt  = r_perf_flush;
  assign perf_freeze_cnt = r_perf_freeze;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle vector table plus reset/perf sequences.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW = 5;

  // {pc_en, fd_en, de_en, em_en, mm_en, mw_en, fd_flush, de_flush, em_flush, mm_flush, mw_flush}
  localparam logic [10:0] RUN_O = 11'b111111_00000;
  localparam logic [10:0] BUB_O = 11'b000111_01000;
  localparam logic [10:0] RED_O = 11'b100111_11000;
  localparam logic [10:0] FRZ_O = 11'b000000_00000;
  localparam logic [10:0] RST_O = 11'b000000_11111;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd, m1_rd;
  logic          id_rs1_used, id_rs2_used, ex_is_load, m1_is_load, ex_redirect, dmem_busy;
  logic          pc_en, fd_en, de_en, em_en, mm_en, mw_en;
  logic          fd_flush, de_flush, em_flush, mm_flush, mw_flush;
  logic [1:0]    ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0]   perf_bubble_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .LU_EX_BUBBLES(2)) dut (
    .clk(clk), .n_rst(n_rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_is_load(ex_is_load), .m1_is_load(m1_is_load), .ex_rd(ex_rd), .m1_rd(m1_rd),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mm_en(mm_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mm_flush(mm_flush),
    .mw_flush(mw_flush), .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_freeze_cnt(perf_freeze_cnt)
`endif
  );

  typedef struct {
    string         name;
    logic [AW-1:0] rs1, rs2, exrd, m1rd;
    logic          u1, u2, exl, m1l, redir, busy;
    logic [10:0]   exp_o;
    logic [1:0]    exp_st;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] o;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input string nm, input logic [AW-1:0] rs1, input logic u1,
                              input logic [AW-1:0] rs2, input logic u2, input logic exl,
                              input logic [AW-1:0] exrd, input logic m1l, input logic [AW-1:0] m1rd,
                              input logic rd, input logic bz, input logic [10:0] o, input logic [1:0] st);
    vec_t v;
    v.name = nm; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.exl = exl; v.exrd = exrd; v.m1l = m1l; v.m1rd = m1rd;
    v.redir = rd; v.busy = bz; v.exp_o = o; v.exp_st = st;
    return v;
  endfunction

  function automatic vec_t idle(input string nm, input logic [10:0] o, input logic [1:0] st);
    return mk(nm, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, o, st);
  endfunction

  function automatic vec_t luex(input string nm, input logic [10:0] o, input logic [1:0] st);
    return mk(nm, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, o, st);
  endfunction

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs1_used = v.u1; id_rs2 = v.rs2; id_rs2_used = v.u2;
    ex_is_load = v.exl; ex_rd = v.exrd; m1_is_load = v.m1l; m1_rd = v.m1rd;
    ex_redirect = v.redir; dmem_busy = v.busy;
  endtask

  task automatic check_now(input string nm, input logic [10:0] o, input logic [1:0] st);
    logic [10:0] got;
    logic        conflict;
    got = {pc_en, fd_en, de_en, em_en, mm_en, mw_en, fd_flush, de_flush, em_flush, mm_flush, mw_flush};
    conflict = (fd_en & fd_flush) | (de_en & de_flush) | (em_en & em_flush) |
               (mm_en & mm_flush) | (mw_en & mw_flush);
    checks++;
    if (got !== o) begin
      failures++;
      $display("FAIL %s outputs got=%b want=%b", nm, got, o);
    end
    checks++;
    if (ctrl_state !== st) begin
      failures++;
      $display("FAIL %s ctrl_state got=%0d want=%0d", nm, ctrl_state, st);
    end
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL %s en_flush_overlap got=%b want=0", nm, conflict);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    sb.push_back('{v.name, v.exp_o, v.exp_st});
    @(negedge clk);
    e = sb.pop_front();
    check_now(e.name, e.o, e.st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    drive(idle("init", RUN_O, 2'd0));

    tbl.push_back(idle("first_after_rst", RUN_O, 2'd0));
    tbl.push_back(luex("lu_ex_x5_b1",     BUB_O, 2'd0));
    tbl.push_back(idle("lu_ex_x5_b2",     BUB_O, 2'd1));
    tbl.push_back(idle("lu_ex_x5_done",   RUN_O, 2'd0));
    tbl.push_back(mk("load_x0", 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, RUN_O, 2'd0));
    tbl.push_back(mk("rs2_unused", 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, RUN_O, 2'd0));
    tbl.push_back(mk("ex_not_load", 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, RUN_O, 2'd0));
    tbl.push_back(mk("lu_m1_rs2", 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, BUB_O, 2'd0));
    tbl.push_back(idle("lu_m1_one_bubble", RUN_O, 2'd0));
    tbl.push_back(mk("lu_m1_x0", 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, RUN_O, 2'd0));
    tbl.push_back(mk("lu_ex_rs2_b1", 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, BUB_O, 2'd0));
    tbl.push_back(mk("stall_ignores_hz", 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, BUB_O, 2'd1));
    tbl.push_back(mk("hz_again_run", 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, BUB_O, 2'd0));
    tbl.push_back(idle("hz_again_b2",     BUB_O, 2'd1));
    tbl.push_back(idle("hz_again_done",   RUN_O, 2'd0));
    tbl.push_back(luex("frz_lu_b1",       BUB_O, 2'd0));
    tbl.push_back(mk("frz_busy1", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, FRZ_O, 2'd1));
    tbl.push_back(mk("frz_busy2", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, FRZ_O, 2'd2));
    tbl.push_back(mk("frz_busy3", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, FRZ_O, 2'd2));
    tbl.push_back(idle("frz_resume_b2",   BUB_O, 2'd2));
    tbl.push_back(idle("frz_done",        RUN_O, 2'd0));
    tbl.push_back(mk("redir_with_lu", 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0, RED_O, 2'd0));
    tbl.push_back(idle("redir_next_run",  RUN_O, 2'd0));
    tbl.push_back(luex("stall_redir_b1",  BUB_O, 2'd0));
    tbl.push_back(mk("stall_redir", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, RED_O, 2'd1));
    tbl.push_back(idle("stall_redir_run", RUN_O, 2'd0));
    tbl.push_back(mk("busy_over_all", 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, FRZ_O, 2'd0));
    tbl.push_back(idle("busy_run_resume", RUN_O, 2'd2));
    tbl.push_back(idle("busy_run_back",   RUN_O, 2'd0));
    tbl.push_back(mk("busy_run2", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, FRZ_O, 2'd0));
    tbl.push_back(luex("resume_lu_b1",    BUB_O, 2'd2));
    tbl.push_back(idle("resume_lu_b2",    BUB_O, 2'd1));
    tbl.push_back(idle("resume_lu_done",  RUN_O, 2'd0));

    #2;
    check_now("reset_hold", RST_O, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset asserted in the middle of a load-use stall
    apply(luex("mid_rst_b1", BUB_O, 2'd0));
    @(posedge clk);
    #1;
    drive(idle("mid_rst", RUN_O, 2'd0));
    #2;
    check_now("mid_rst_stall", BUB_O, 2'd1);
    n_rst = 1'b0;
    #1;
    check_now("mid_rst_async", RST_O, 2'd0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    apply(idle("mid_rst_release", RUN_O, 2'd0));

    // One lu_ex event, one redirect, four busy cycles
    apply(luex("perf_b1", BUB_O, 2'd0));
    apply(idle("perf_b2", BUB_O, 2'd1));
    apply(mk("perf_redir", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, RED_O, 2'd0));
    for (int k = 0; k < 4; k++)
      apply(mk("perf_busy", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, FRZ_O,
               (k == 0) ? 2'd0 : 2'd2));
    apply(idle("perf_resume", RUN_O, 2'd2));
    @(posedge clk);
    #1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checks++;
    if (perf_bubble_cnt !== 32'd2) begin
      failures++;
      $display("FAIL perf_bubble got=%0d want=2", perf_bubble_cnt);
    end
    checks++;
    if (perf_flush_cnt !== 32'd1) begin
      failures++;
      $display("FAIL perf_flush got=%0d want=1", perf_flush_cnt);
    end
    checks++;
    if (perf_freeze_cnt !== 32'd4) begin
      failures++;
      $display("FAIL perf_freeze got=%0d want=4", perf_freeze_cnt);
    end
`endif
    check_now("final_run", RUN_O, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
